secuencia_param: RTL and testbench

Parametrised serial sequence detector: compares a 1-bit input stream against an N-bit pattern that can be loaded at run time. Overlapping or non-overlapping detection is selectable at run time, and the output can be Mealy (same-cycle, combinational) or Moore (registered, one cycle later). A saturating hit counter is included. It is the general-purpose replacement for the fixed two-state "consecutive ones" detectors in the sequence-detection exercises and drives LEDs and counters on the board.

---
 rtl/secuencia_param_pkg.sv | 24 ++
 rtl/secuencia_defs.vh | 16 +
 rtl/secuencia_param_contador_sat.sv | 36 +++
 rtl/secuencia_param.sv | 93 +++++++++
 tb/tb_secuencia_param.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/secuencia_param_pkg.sv
// rtl/secuencia_param_pkg.sv - shared types, constants and helpers for the sequence detector
//
// Re-exports the constants of secuencia_defs.vh so that RTL and bench
// share one definition, and adds the output-mode enum and legal N range.
package secuencia_param_pkg;

  `include "secuencia_defs.vh"

  // Legal pattern lengths
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // Output mode as seen by the output mux
  typedef enum logic {
    SALIDA_MEALY = 1'b0,
    SALIDA_MOORE = 1'b1
  } modo_e;

  // Width of the fill counter: must hold 0..n-1, never narrower than 1 bit
  function automatic int anchura_fill(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/secuencia_defs.vh
// rtl/secuencia_defs.vh - shared mode, overlap and reset-pattern constants for secuencia_param
`ifndef SECUENCIA_DEFS_VH
`define SECUENCIA_DEFS_VH

// Output mode select values for the moore input
localparam logic MODO_MEALY = 1'b0;
localparam logic MODO_MOORE = 1'b1;

// Overlap select values for the solapado input
localparam logic SOLAPA_NO = 1'b0;
localparam logic SOLAPA_SI = 1'b1;

// Pattern loaded at reset (all ones); sliced to N bits by the user
localparam logic [15:0] PATRON_RESET = 16'hFFFF;

`endif

// File: rtl/secuencia_param_contador_sat.sv
// rtl/secuencia_param_contador_sat.sv - saturating up-counter with clear-over-increment priority
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset, clears q
//   clr    in   synchronous clear, wins over inc
//   inc    in   increment request, ignored once q is all ones
//   q      out  CW-bit count
module contador_sat #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);

  logic [CW-1:0] r_q;
  logic          w_lleno;

  assign w_lleno = &r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !w_lleno) begin
      r_q <= r_q + CW'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/secuencia_param.sv
// rtl/secuencia_param.sv - run-time loadable N-bit serial sequence detector with hit counter
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   en          in   sample strobe; w is consumed only when en=1
//   w           in   serial data bit
//   patron      in   N-bit pattern, patron[N-1] oldest bit, patron[0] newest
//   cargar      in   load strobe; copies patron, restarts matching
//   solapado    in   1 = overlapping detection, 0 = non-overlapping
//   moore       in   1 = registered output, 0 = combinational Mealy output
//   clr_cuenta  in   synchronous clear of the hit counter
//   z           out  detection flag
//   cuenta      out  saturating hit count
module secuencia_param
  import secuencia_param_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          w,
  input  logic [N-1:0]  patron,
  input  logic          cargar,
  input  logic          solapado,
  input  logic          moore,
  input  logic          clr_cuenta,
  output logic          z,
  output logic [CW-1:0] cuenta
);

  localparam int            FW       = anchura_fill(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-1:0]  r_pat;
  logic [N-2:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic          r_z;

  logic [N-1:0]  w_ventana;
  logic          w_lleno;
  logic          w_hit;
  modo_e         w_modo;

  // Current window: previous N-1 accepted samples plus this cycle's bit.
  // Building it by concatenation also gives the next history for any N >= 2.
  assign w_ventana = {r_hist, w};
  assign w_lleno   = (r_fill == FILL_MAX);

  // A sample arriving with cargar is discarded, so it can never hit.
  assign w_hit = en & ~cargar & w_lleno & (w_ventana == r_pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= PATRON_RESET[N-1:0];
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else begin
      r_z <= w_hit;
      if (cargar) begin
        // History is kept; fill restarts so stale bits can never match
        r_pat  <= patron;
        r_fill <= '0;
      end else if (en) begin
        r_hist <= w_ventana[N-2:0];
        if (w_hit && (solapado == SOLAPA_NO)) begin
          // Non-overlap: the bits of this hit may not seed the next one
          r_fill <= '0;
        end else if (!w_lleno) begin
          r_fill <= r_fill + FW'(1);
        end
      end
    end
  end

  // moore may toggle at any time; z simply follows the mux
  assign w_modo = modo_e'(moore);
  assign z      = (w_modo == SALIDA_MOORE) ? r_z : w_hit;

  contador_sat #(
    .CW (CW)
  ) u_cuenta (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cuenta),
    .inc   (w_hit),
    .q     (cuenta)
  );

endmodule

// File: tb/tb_secuencia_param.sv
// tb/tb_secuencia_param.sv - scoreboard bench for secuencia_param against a queue-based reference
module tb_secuencia_param;
  import secuencia_param_pkg::*;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          w;
  logic [N-1:0]  patron;
  logic          cargar;
  logic          solapado;
  logic          moore;
  logic          clr_cuenta;
  logic          z;
  logic [CW-1:0] cuenta;

  secuencia_param #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .w          (w),
    .patron     (patron),
    .cargar     (cargar),
    .solapado   (solapado),
    .moore      (moore),
    .clr_cuenta (clr_cuenta),
    .z          (z),
    .cuenta     (cuenta)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit z;
    int c;
    int ciclo;
  } esperado_t;

  esperado_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_ciclo  = 0;
  bit fin      = 0;

  // Reference model: the accepted samples since the last restart point
  // (reset, load, or a non-overlapping hit), the active pattern, the
  // hit of the previous edge and the hit count.
  bit [N-1:0] m_pat;
  bit         m_q[$];
  bit         m_zq;
  int         m_cnt;

  // Globals selecting the mode of the running scenario
  bit         g_solap;
  bit         g_moore;
  bit [N-1:0] g_pat;

  function automatic bit m_hit(input bit en_i, input bit cargar_i, input bit w_i);
    bit [N-1:0] v;
    if (!en_i || cargar_i || m_q.size() < N - 1) return 1'b0;
    for (int k = 0; k < N - 1; k++) v[N-1-k] = m_q[m_q.size() - (N - 1) + k];
    v[0] = w_i;
    return v == m_pat;
  endfunction

  task automatic ciclo(input bit rst_i, input bit en_i, input bit w_i,
                       input bit cargar_i, input bit clr_i);
    esperado_t e;
    bit h;
    @(posedge clk);
    #1;
    reset      = rst_i;
    en         = en_i;
    w          = w_i;
    cargar     = cargar_i;
    clr_cuenta = clr_i;
    patron     = g_pat;
    solapado   = g_solap;
    moore      = g_moore;
    n_ciclo++;
    e.ciclo = n_ciclo;
    if (!rst_i) begin
      m_pat = '1;
      m_q.delete();
      m_zq  = 0;
      m_cnt = 0;
      e.z = 0;
      e.c = 0;
      sb.push_back(e);
    end else begin
      h   = m_hit(en_i, cargar_i, w_i);
      e.z = g_moore ? m_zq : h;
      e.c = m_cnt;
      sb.push_back(e);
      m_zq = h;
      if (clr_i) m_cnt = 0;
      else if (h && m_cnt < CMAX) m_cnt++;
      if (cargar_i) begin
        m_pat = g_pat;
        m_q.delete();
      end else if (en_i) begin
        if (h && !g_solap) m_q.delete();
        else begin
          m_q.push_back(w_i);
          if (m_q.size() > N - 1) void'(m_q.pop_front());
        end
      end
    end
  endtask

  task automatic flujo(input bit [15:0] bits, input int len);
    bit [15:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) ciclo(1, 1, b[i], 0, 0);
  endtask

  task automatic cargar_pat(input bit [N-1:0] p);
    g_pat = p;
    ciclo(1, 0, 0, 1, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (z !== e.z) begin
          n_errors++;
          $display("FAIL z cycle %0d: got %0b expected %0b", e.ciclo, z, e.z);
        end
        n_checks++;
        if (int'(cuenta) != e.c || $isunknown(cuenta)) begin
          n_errors++;
          $display("FAIL cuenta cycle %0d: got %0d expected %0d", e.ciclo, cuenta, e.c);
        end
      end
    end
  end

  initial begin
    reset = 0; en = 0; w = 0; cargar = 0; clr_cuenta = 0;
    g_pat = '1; g_solap = SOLAPA_SI; g_moore = MODO_MEALY;
    patron = '1; solapado = 1; moore = 0;
    m_pat = '1; m_zq = 0; m_cnt = 0;

    ciclo(0, 0, 0, 0, 0);
    ciclo(0, 1, 1, 0, 0);

    // Reset pattern 1111, overlapping, Mealy: hits on samples 4,5,6
    flujo(16'b111111, 6);
    ciclo(1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 1);

    // 1010 overlapping then non-overlapping
    cargar_pat(4'b1010);
    flujo(16'b101010, 6);
    g_solap = SOLAPA_NO;
    cargar_pat(4'b1010);
    flujo(16'b101010, 6);

    // 1011 Moore then Mealy
    g_solap = SOLAPA_SI;
    g_moore = MODO_MOORE;
    cargar_pat(4'b1011);
    flujo(16'b1011, 4);
    ciclo(1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0);
    g_moore = MODO_MEALY;
    cargar_pat(4'b1011);
    flujo(16'b1011, 4);
    ciclo(1, 0, 0, 0, 1);

    // en gaps do not break a partial match
    cargar_pat(4'b1011);
    flujo(16'b10, 2);
    repeat (3) ciclo(1, 0, 1, 0, 0);
    flujo(16'b11, 2);

    // Load on the sample-4 cycle discards it
    cargar_pat(4'b1011);
    flujo(16'b101, 3);
    ciclo(1, 1, 1, 1, 0);
    flujo(16'b1, 1);
    flujo(16'b1011, 4);

    // Saturation with CW=2, then clear together with a hit
    cargar_pat(4'b1111);
    flujo(16'b1111111111, 10);
    ciclo(1, 1, 1, 0, 1);
    flujo(16'b11, 2);

    // Reset mid-sequence
    cargar_pat(4'b1011);
    flujo(16'b101, 3);
    ciclo(0, 1, 1, 0, 0);
    g_pat = 4'b1011;
    cargar_pat(4'b1011);
    flujo(16'b1, 1);
    flujo(16'b1011, 4);

    // Randomized traffic with small patterns and mode changes
    for (int i = 0; i < 800; i++) begin
      bit r_en, r_cg, r_clr, r_rst;
      if ($urandom_range(0, 39) == 0) begin
        g_solap = 1'($urandom_range(0, 1));
        g_moore = 1'($urandom_range(0, 1));
      end
      r_cg  = ($urandom_range(0, 29) == 0);
      if (r_cg) g_pat = N'($urandom);
      r_en  = ($urandom_range(0, 4) != 0);
      r_clr = ($urandom_range(0, 24) == 0);
      r_rst = ($urandom_range(0, 149) != 0);
      ciclo(r_rst, r_en, 1'($urandom_range(0, 1)), r_cg, r_clr);
    end
    ciclo(1, 0, 0, 0, 0);

    fin = 1;
  end

  initial begin
    wait (fin);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of stimulus");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
